enc_bind_sched: RTL and testbench

ENC_BIND_SCHED -- requirements
Module: enc_bind_sched

---
 rtl/enc_pkg.sv | 17 +
 rtl/enc_bind_sched.sv | 94 +++++++++
 tb/tb_enc_bind_sched.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared encoder definitions: hypervector geometry and the
// bind scheduler state type.
package enc_pkg;

    localparam int HV_DIM          = 2048;
    localparam int FEATURES_PER_CC = 64;
    localparam int NUM_CHUNKS      = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BIND,
        S_EMIT,
        S_DONE
    } enc_sched_state_t;

endpackage

// File: rtl/enc_bind_sched.sv
// Bind scheduler: walks NUM_CHUNKS feature chunks per sample,
// fetching each chunk, strobing the binder packs, then emitting
// the shifted HV to the bundler under valid/ready.
// Ports: clk, nrst (sync, active-low), start, abort, feat_valid,
// feat_ready, start_encoding, chunk_idx, bind_valid,
// bundle_ready, busy, done, stall_cnt.
module enc_bind_sched #(
    parameter int NUM_CHUNKS = 10,
    parameter int STALL_W    = 16,
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    input  logic               feat_valid,
    output logic               feat_ready,
    output logic               start_encoding,
    output logic [IDX_W-1:0]   chunk_idx,
    output logic               bind_valid,
    input  logic               bundle_ready,
    output logic               busy,
    output logic               done,
    output logic [STALL_W-1:0] stall_cnt
);

    import enc_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    enc_sched_state_t   state, state_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [STALL_W-1:0] stall_nxt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= S_IDLE;
            chunk_idx <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            chunk_idx <= idx_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = chunk_idx;
        stall_nxt = stall_cnt;
        // Abort wins over every transition and freezes both counters.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_FETCH;
                        idx_nxt   = '0;
                        stall_nxt = '0;
                    end
                end
                S_FETCH: begin
                    if (feat_valid)
                        state_nxt = S_BIND;
                end
                // Binder output is registered: one cycle, then emit.
                S_BIND: state_nxt = S_EMIT;
                S_EMIT: begin
                    if (bundle_ready) begin
                        if (chunk_idx == LAST_IDX) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_FETCH;
                            idx_nxt   = chunk_idx + IDX_W'(1);
                        end
                    end else if (stall_cnt != '1) begin
                        stall_nxt = stall_cnt + STALL_W'(1);
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore outputs, decoded from the state register only.
    assign feat_ready     = (state == S_FETCH);
    assign start_encoding = (state == S_BIND);
    assign bind_valid     = (state == S_EMIT);
    assign done           = (state == S_DONE);
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_enc_bind_sched.sv
// Directed bench for enc_bind_sched: nominal flow, back-pressure,
// fetch starvation, abort, mid-sample reset, stall saturation.
module tb_enc_bind_sched;

    localparam int N = 10;

    logic clk = 1'b0;
    logic nrst, start, abort, feat_valid, bundle_ready;

    logic       feat_ready, start_encoding, bind_valid;
    logic       busy, done;
    logic [3:0] chunk_idx;
    logic [15:0] stall_cnt;

    logic       feat_ready4, start_encoding4, bind_valid4;
    logic       busy4, done4;
    logic [3:0] chunk_idx4;
    logic [3:0] stall_cnt4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    enc_bind_sched #(.NUM_CHUNKS(N), .STALL_W(16)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .start_encoding(start_encoding), .chunk_idx(chunk_idx),
        .bind_valid(bind_valid), .bundle_ready(bundle_ready),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    enc_bind_sched #(.NUM_CHUNKS(N), .STALL_W(4)) dut4 (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .feat_valid(feat_valid), .feat_ready(feat_ready4),
        .start_encoding(start_encoding4), .chunk_idx(chunk_idx4),
        .bind_valid(bind_valid4), .bundle_ready(bundle_ready),
        .busy(busy4), .done(done4), .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full sample. Windows [a,b] give the cycles (relative to
    // start sampled at cycle 0) where an input is forced; a>b or
    // (0,0) means never.
    task automatic run_sample(input int rl_a, input int rl_b,
                              input int vl_a, input int vl_b,
                              input int sh_a, input int sh_b,
                              input int exp_done,
                              input int exp_stall,
                              input int exp_stall4);
        int strobes = 0;
        int ndone = 0;
        int ndone4 = 0;
        int dcyc = -1;
        start = 1'b1;
        abort = 1'b0;
        feat_valid = 1'b1;
        bundle_ready = 1'b1;
        cyc = 0;
        tick();
        while (cyc <= exp_done + 1) begin
            start = (cyc >= sh_a && cyc <= sh_b);
            feat_valid = !(cyc >= vl_a && cyc <= vl_b);
            bundle_ready = !(cyc >= rl_a && cyc <= rl_b);
            if (start_encoding) begin
                check("idx_at_strobe", chunk_idx, strobes);
                strobes++;
            end
            if (done) begin
                ndone++;
                dcyc = cyc;
            end
            if (done4) ndone4++;
            check("onehot", $countones({feat_ready, start_encoding,
                                        bind_valid}) <= 1, 1);
            check("busy", busy, cyc <= exp_done);
            if (cyc >= rl_a && cyc <= rl_b)
                check("held_valid", bind_valid, 1);
            if (cyc >= vl_a && cyc <= vl_b) begin
                check("starve_ready", feat_ready, 1);
                check("starve_strobe", start_encoding, 0);
            end
            tick();
        end
        start = 1'b0;
        bundle_ready = 1'b1;
        feat_valid = 1'b1;
        check("done_cycle", dcyc, exp_done);
        check("done_count", ndone, 1);
        check("done4_count", ndone4, 1);
        check("strobes", strobes, N);
        check("stall", stall_cnt, exp_stall);
        check("stall4", stall_cnt4, exp_stall4);
        check("idle_after", busy, 0);
    endtask

    initial begin
        nrst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        feat_valid = 1'b1;
        bundle_ready = 1'b1;
        tick();
        tick();
        check("rst_outs", {feat_ready, start_encoding, bind_valid,
                           busy, done, chunk_idx, stall_cnt}, 0);
        check("rst_outs4", {feat_ready4, start_encoding4, bind_valid4,
                            busy4, done4, chunk_idx4, stall_cnt4}, 0);
        nrst = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Nominal: strobes 2,5,..,29, done at 31.
        run_sample(0, 0, 0, 0, 0, 0, 31, 0, 0);

        // Back-pressure on chunk 3 EMIT (cycle 12) for 4 cycles.
        run_sample(12, 15, 0, 0, 0, 0, 35, 4, 4);

        // feat_valid low for 6 cycles in FETCH of chunk 0.
        run_sample(0, 0, 1, 6, 0, 0, 37, 0, 0);

        // start held during the sample, 20 stalls from chunk 0 EMIT.
        run_sample(3, 22, 0, 0, 2, 50, 51, 20, 15);

        // Abort in EMIT of chunk 5, after 2 stalls on chunk 2.
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 20) begin
            bundle_ready = !(cyc == 9 || cyc == 10);
            tick();
        end
        bundle_ready = 1'b1;
        check("ab_valid", bind_valid, 1);
        check("ab_idx", chunk_idx, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle", {busy, feat_ready, start_encoding,
                          bind_valid, done}, 0);
        check("ab_stall", stall_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ab_nodone", {busy, done}, 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_restart_idx", chunk_idx, 0);
        check("ab_restart_fetch", feat_ready, 1);
        check("ab_restart_stall", stall_cnt, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab2_idle", busy, 0);

        // Reset during BIND of chunk 7 (one stall on chunk 1).
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 24) begin
            bundle_ready = (cyc != 6);
            tick();
        end
        bundle_ready = 1'b1;
        check("rb_strobe", start_encoding, 1);
        check("rb_idx", chunk_idx, 7);
        check("rb_stall_pre", stall_cnt, 1);
        nrst = 1'b0;
        start = 1'b1;
        tick();
        check("rb_outs", {feat_ready, start_encoding, bind_valid,
                          busy, done, chunk_idx, stall_cnt}, 0);
        tick();
        check("rb_start_ign", busy, 0);
        nrst = 1'b1;
        start = 1'b0;
        tick();
        check("rb_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rb_restart_fetch", feat_ready, 1);
        check("rb_restart_idx", chunk_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
